// File: rtl/lsq_data_mem.sv
// Data-memory responder for the LSQ: single-cycle memory access at accept, fixed-latency
// pipeline, then a first-word-fall-through response FIFO with credit-based request flow control.
module lsq_data_mem #(
  parameter int    MEM_WORDS  = 256,
  parameter int    LATENCY    = 2,
  parameter int    RESP_DEPTH = 4,
  parameter int    TAG_W      = 6,
  parameter string INIT_FILE  = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_is_store,
  output logic [31:0]      resp_rdata,
  output logic             resp_err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int OW = $clog2(LATENCY + RESP_DEPTH + 1);
  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             is_store;
    logic             err;
    logic [31:0]      data;
  } resp_t;

  logic [31:0]        mem_r [MEM_WORDS];
  logic [LATENCY-1:0] pipe_valid_r;
  resp_t              pipe_r [LATENCY];
  resp_t              fifo_r [RESP_DEPTH];
  logic [PW-1:0]      rd_ptr_r;
  logic [PW-1:0]      wr_ptr_r;
  logic [CW-1:0]      cnt_r;
  logic [OW-1:0]      outstanding_s;
  logic               accept_s;
  logic               err_s;
  logic               push_s;
  logic               pop_s;
  logic [AW-1:0]      word_idx_s;
  logic [31:0]        rd_word_s;
  logic [31:0]        lane_s;
  logic [31:0]        ld_data_s;
  logic [31:0]        wr_data_s;
  logic [3:0]         be_s;
  resp_t              new_s;
  resp_t              head_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  // Memory starts at zero; memory is never touched by reset.
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_r[i] = 32'h0;
  end

  assign accept_s   = req_valid && req_ready && !rst;
  assign word_idx_s = req_addr[AW+1:2];
  assign rd_word_s  = mem_r[word_idx_s];
  assign lane_s     = rd_word_s >> {req_addr[1:0], 3'b000};

  // Decode error, load extension and store byte enables for the presented request.
  always_comb begin
    err_s     = (req_size == 2'b11)
             || ((req_size == 2'b01) && req_addr[0])
             || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
             || ({2'b00, req_addr[31:2]} >= MEM_WORDS_L);
    ld_data_s = 32'h0;
    wr_data_s = 32'h0;
    be_s      = 4'b0000;
    case (req_size)
      2'b00: begin
        ld_data_s = req_unsigned ? {24'h0, lane_s[7:0]} : {{24{lane_s[7]}}, lane_s[7:0]};
        wr_data_s = {4{req_wdata[7:0]}};
        be_s      = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        ld_data_s = req_unsigned ? {16'h0, lane_s[15:0]} : {{16{lane_s[15]}}, lane_s[15:0]};
        wr_data_s = {2{req_wdata[15:0]}};
        be_s      = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        ld_data_s = lane_s;
        wr_data_s = req_wdata;
        be_s      = 4'b1111;
      end
      default: begin
        ld_data_s = 32'h0;
        wr_data_s = 32'h0;
        be_s      = 4'b0000;
      end
    endcase
    new_s.tag      = req_tag;
    new_s.is_store = req_is_store;
    new_s.err      = err_s;
    new_s.data     = (err_s || req_is_store) ? 32'h0 : ld_data_s;
  end

  // Store write at the accept edge so any later load observes it.
  always_ff @(posedge clk) begin
    if (accept_s && req_is_store && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) mem_r[word_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
      end
    end
  end

  // Fixed-latency pipeline; never stalls because credit limits what can enter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_r[i] <= '0;
    end else begin
      pipe_valid_r[0] <= accept_s;
      pipe_r[0]       <= new_s;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_r[i]       <= pipe_r[i-1];
      end
    end
  end

  assign push_s = pipe_valid_r[LATENCY-1];
  assign pop_s  = (cnt_r != CW'(0)) && resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      cnt_r    <= CW'(0);
      for (int i = 0; i < RESP_DEPTH; i++) fifo_r[i] <= '0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= pipe_r[LATENCY-1];
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Credit is computed only from registered state, so resp_ready never reaches req_ready.
  always_comb begin
    outstanding_s = OW'(cnt_r);
    for (int i = 0; i < LATENCY; i++) outstanding_s = outstanding_s + OW'(pipe_valid_r[i]);
  end

  assign req_ready     = (outstanding_s < OW'(RESP_DEPTH));
  assign head_s        = fifo_r[rd_ptr_r];
  assign resp_valid    = (cnt_r != CW'(0));
  assign resp_tag      = resp_valid ? head_s.tag : TAG_W'(0);
  assign resp_is_store = resp_valid && head_s.is_store;
  assign resp_err      = resp_valid && head_s.err;
  assign resp_rdata    = resp_valid ? head_s.data : 32'h0;

endmodule
